// File: rtl/alu_pipe_n.sv
// alu_pipe_n: single-issue ALU with a valid/ready handshake on both sides.
//
// Single-cycle ops (add, sub, and, or, xor, signed compares) produce a registered
// result one cycle after acceptance. MUL is an iterative shift-add unit that
// retires one multiplier bit per cycle. It is compiled in only when the macro
// ALU_PIPE_MUL_EN is defined. Without the macro, op 10000 is reported as illegal.
//
// Ports:
//   clk        clock; all state updates on its rising edge
//   rst        synchronous active-high reset
//   in_valid   request valid (A, B, op)
//   in_ready   request accepted this cycle when in_valid is also high
//   A, B       WIDTH-bit operands
//   op         5-bit operation code
//   out_valid  result, zero_out and err are valid
//   out_ready  consumer takes the result this cycle
//   result     registered result
//   zero_out   registered zero flag (A+B or A-B == 0, or product == 0 for MUL)
//   err        registered illegal-op flag
module alu_pipe_n #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_out,
  output logic             err
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e state_q;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             lt;
  logic             gt;
  logic             eq;

  assign sum  = A + B;
  assign diff = A - B;
  // Native signed compares are exact; no overflow-prone subtraction involved.
  assign lt   = $signed(A) < $signed(B);
  assign gt   = $signed(B) < $signed(A);
  assign eq   = (A == B);

  logic [WIDTH-1:0] alu_res;
  logic             alu_zero;
  logic             alu_err;
`ifdef ALU_PIPE_MUL_EN
  logic             is_mul;
`endif

  // Decode for everything that completes in one cycle. Illegal ops fall
  // through with the defaults: result 0, zero 1, err 1.
  always_comb begin
    alu_res  = '0;
    alu_zero = 1'b1;
    alu_err  = 1'b1;
`ifdef ALU_PIPE_MUL_EN
    is_mul   = 1'b0;
`endif
    if (!op[4]) begin
      alu_err  = 1'b0;
      // Zero flag follows the adder/subtractor, independent of the selected op.
      alu_zero = op[0] ? (diff == '0) : (sum == '0);
      case (op[2:0])
        3'b000:  alu_res    = sum;
        3'b001:  alu_res    = diff;
        3'b010:  alu_res    = A & B;
        3'b011:  alu_res[0] = op[3] ? gt : lt;
        3'b100:  alu_res    = A ^ B;
        3'b101:  alu_res[0] = op[3] ? !eq : eq;
        3'b110:  alu_res    = A | B;
        default: alu_res[0] = op[3] ? !lt : !gt;  // sle / sge
      endcase
    end
`ifdef ALU_PIPE_MUL_EN
    else if (op[3:0] == 4'b0000) begin
      is_mul  = 1'b1;
      alu_err = 1'b0;
    end
`endif
  end

  logic accept;

  assign in_ready  = (state_q == StIdle) | ((state_q == StDone) & out_ready);
  assign out_valid = (state_q == StDone);
  assign accept    = in_valid & in_ready;

`ifdef ALU_PIPE_MUL_EN
  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] acc_nxt;

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier LSB is set. Only the low WIDTH bits are kept.
  assign acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      result   <= '0;
      zero_out <= 1'b0;
      err      <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (accept) begin
`ifdef ALU_PIPE_MUL_EN
            if (is_mul) begin
              state_q  <= StMul;
              mcand_q  <= A;
              mplier_q <= B;
              acc_q    <= '0;
              cnt_q    <= '0;
            end else
`endif
            begin
              state_q  <= StDone;
              result   <= alu_res;
              zero_out <= alu_zero;
              err      <= alu_err;
            end
          end else if ((state_q == StDone) && out_ready) begin
            state_q <= StIdle;
          end
        end
`ifdef ALU_PIPE_MUL_EN
        StMul: begin
          acc_q    <= acc_nxt;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            state_q  <= StDone;
            result   <= acc_nxt;
            zero_out <= (acc_nxt == '0);
            err      <= 1'b0;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe_n.sv
`timescale 1ns/1ps
module tb_alu_pipe_n;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero_out;
  logic        err;

  int total = 0;
  int bad   = 0;

`ifdef ALU_PIPE_MUL_EN
  localparam bit MulOn = 1'b1;
`else
  localparam bit MulOn = 1'b0;
`endif

  alu_pipe_n #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero_out (zero_out),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: {err, zero, result} straight from the op table.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] o);
    longint      sa, sb;
    logic [31:0] r;
    logic        z, e;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    r  = 32'd0;
    z  = 1'b1;
    e  = 1'b1;
    if (!o[4]) begin
      e = 1'b0;
      z = o[0] ? (a == b) : ((a + b) == 32'd0);
      case (o[2:0])
        3'd0: r = a + b;
        3'd1: r = a - b;
        3'd2: r = a & b;
        3'd3: r = {31'd0, (o[3] ? (sa > sb) : (sa < sb))};
        3'd4: r = a ^ b;
        3'd5: r = {31'd0, (o[3] ? (sa != sb) : (sa == sb))};
        3'd6: r = a | b;
        3'd7: r = {31'd0, (o[3] ? (sa >= sb) : (sa <= sb))};
        default: r = 32'd0;
      endcase
    end else if (MulOn && o == 5'b10000) begin
      p = {32'd0, a} * {32'd0, b};
      r = p[31:0];
      z = (r == 32'd0);
      e = 1'b0;
    end
    return {e, z, r};
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [4:0] rand_single_op();
    if ($urandom_range(0, 7) < 6) return {1'b0, 4'($urandom_range(0, 15))};
    return {1'b1, 4'($urandom_range(1, 15))};
  endfunction

  // One transaction from IDLE: accept, wait for the result, stall, release.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] o,
                        input int stall);
    logic [33:0] e;
    int          lat;
    int          exp_lat;
    e       = model(a, b, o);
    exp_lat = (MulOn && o == 5'b10000) ? 33 : 1;
    out_ready = 1'b0;
    check_eq("idle_in_ready", in_ready, 1);
    A = a; B = b; op = o; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    A = $urandom; B = $urandom; op = 5'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      check_eq("busy_in_ready", in_ready, 0);
      step();
      lat++;
    end
    check_eq("latency", lat, exp_lat);
    check_eq("result", result, e[31:0]);
    check_eq("zero_out", zero_out, e[32]);
    check_eq("err", err, e[33]);
    for (int k = 0; k < stall; k++) begin
      step();
      check_eq("stall_result", result, e[31:0]);
      check_eq("stall_flags", {err, zero_out, out_valid, in_ready}, {e[33], e[32], 2'b10});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("released", out_valid, 0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [4:0]  o;
    logic [33:0] e;
    int          seen;

    // Reset, with a simultaneous request that must be ignored.
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    A = 32'd7; B = 32'd9; op = 5'b00000;
    step();
    step();
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_flags", {zero_out, err}, 2'b00);
    in_valid = 1'b0;
    rst = 1'b0;
    step();
    check_eq("post_rst_in_ready", in_ready, 1);
    check_eq("post_rst_out_valid", out_valid, 0);

    // Directed cases.
    run_op(32'd5, 32'd5, 5'b00001, 0);
    run_op(32'h8000_0000, 32'h7FFF_FFFF, 5'b00011, 0);
    run_op(32'h8000_0000, 32'h7FFF_FFFF, 5'b01011, 0);
    run_op(32'h0001_0003, 32'h0000_0005, 5'b10000, 0);
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 5'b11010, 1);

    // add 1+2 with a 3-cycle stall, then a back-to-back xor at the handoff.
    A = 32'd1; B = 32'd2; op = 5'b00000; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check_eq("add_valid", out_valid, 1);
    check_eq("add_result", result, 3);
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("add_stall_result", result, 3);
      check_eq("add_stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1; in_valid = 1'b1;
    A = 32'h0000_F0F0; B = 32'h0000_FF00; op = 5'b00100;
    #1;
    check_eq("handoff_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check_eq("xor_valid", out_valid, 1);
    check_eq("xor_result", result, 32'h0000_0FF0);
    step();
    out_ready = 1'b0;
    check_eq("xor_released", out_valid, 0);

    // Reset mid-operation aborts with no result.
`ifdef ALU_PIPE_MUL_EN
    A = 32'd3; B = 32'd4; op = 5'b10000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (9) step();
`else
    A = 32'd3; B = 32'd4; op = 5'b00000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("abort_out_valid", out_valid, 0);
    check_eq("abort_result", result, 0);
    check_eq("abort_in_ready", in_ready, 1);
    seen = 0;
    repeat (40) begin
      step();
      if (out_valid) seen++;
    end
    check_eq("abort_no_result", seen, 0);

    // Randomized transactions with random stalls.
    for (int i = 0; i < 25; i++) begin
      a = rand_operand();
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = -a;
        default: b = rand_operand();
      endcase
      case ($urandom_range(0, 9))
        7:       o = 5'b10000;
        8, 9:    o = {1'b1, 4'($urandom_range(0, 15))};
        default: o = {1'b0, 4'($urandom_range(0, 15))};
      endcase
      run_op(a, b, o, $urandom_range(0, 2));
    end

    // Streaming single-cycle ops at one per cycle.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 30; i++) begin
      a = rand_operand();
      b = ($urandom_range(0, 3) == 0) ? a : rand_operand();
      o = rand_single_op();
      A = a; B = b; op = o;
      e = model(a, b, o);
      step();
      check_eq("stream_valid", out_valid, 1);
      check_eq("stream_result", result, e[31:0]);
      check_eq("stream_flags", {err, zero_out}, e[33:32]);
      check_eq("stream_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    check_eq("stream_end", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_pipe_n.md
ALU_PIPE_N -- requirements
Module: alu_pipe_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand/result width in bits, legal range 4..64.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit, meaning the operands and op are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit, meaning a request is accepted this cycle.
REQ-006 The block SHALL have ports A and B, inputs, WIDTH bits each, the operands.
REQ-007 The block SHALL have port op, input, 5 bits, the operation code (REQ-012).
REQ-008 The block SHALL have port out_valid, output, 1 bit, meaning result/zero_out/err are valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit, meaning the consumer takes the result this cycle.
REQ-010 The block SHALL have port result, output, WIDTH bits, the registered result.
REQ-011 The block SHALL have ports zero_out and err, outputs, 1 bit each: the registered zero flag and the illegal-op flag.

Function
REQ-012 Ops with op[4]=0 SHALL decode op[2:0] as: 000 add, 001 sub, 010 and, 011 slt/sgt, 100 xor, 101 seq/sne, 110 or, 111 sle/sge; op[3] selects the second form (sgt, sne, sge), and for 000/001 op[3] has no effect.
REQ-013 add/sub SHALL wrap modulo 2^WIDTH; carry and overflow are discarded.
REQ-014 Compare ops SHALL be signed two's-complement comparisons correct under overflow; true gives result 1 and false gives 0, zero-extended to WIDTH.
REQ-015 op=10000 (MUL) SHALL give the low WIDTH bits of the unsigned product A*B, computed by an iterative shift-add unit at one bit per cycle.
REQ-016 Every other op with op[4]=1 SHALL complete in one cycle with result=0, zero_out=1, err=1; all legal ops give err=0.
REQ-017 zero_out SHALL be 1 when A minus B (for op[0]=1) or A plus B (for op[0]=0) equals 0 with op[4]=0, and 1 when the product equals 0 for MUL.
REQ-018 The state machine SHALL have three states: IDLE, MUL, DONE.
  - IDLE: in_valid with a single-cycle op goes to DONE; in_valid with MUL goes to MUL.
  - MUL: stays for exactly WIDTH cycles, then goes to DONE.
  - DONE: when out_ready, goes to IDLE, or accepts a new request directly when in_valid.
REQ-019 in_ready SHALL equal (state==IDLE) OR (state==DONE AND out_ready), and SHALL be 0 in MUL.
REQ-020 out_valid SHALL be 1 exactly in DONE.
REQ-021 A request SHALL be accepted when in_valid AND in_ready; A, B and op are captured at acceptance and later input changes have no effect.
REQ-022 Latency SHALL be: a single-cycle op accepted at edge N gives out_valid after edge N+1; MUL gives out_valid after edge N+WIDTH+1.
REQ-023 Throughput for single-cycle ops SHALL be one per cycle when out_ready is held at 1.
REQ-024 While out_valid=1 and out_ready=0, result, zero_out and err SHALL hold stable.
REQ-025 in_valid while in_ready=0 SHALL be ignored; the source must hold its request.

Reset
REQ-026 When rst=1 at a clock edge, state SHALL go to IDLE, out_valid to 0, and result, zero_out, err and the MUL counter and accumulator to 0.
REQ-027 rst asserted during MUL or DONE SHALL abort the operation, with no result produced.
REQ-028 in_ready SHALL read 1 in the cycle after reset is released.
REQ-029 rst SHALL take priority over a simultaneous in_valid.

Configuration
REQ-030 Macro ALU_PIPE_MUL_EN SHALL, when defined, compile in the MUL state, the shift-add datapath and the counter.
REQ-031 Without ALU_PIPE_MUL_EN, op=10000 SHALL be treated as illegal per REQ-016, the MUL state SHALL be unreachable, and no multiplier logic SHALL remain.

Verification (WIDTH=32)
REQ-032 sub with A=5, B=5, op=00001 -> result=0, zero_out=1, err=0, out_valid one cycle after acceptance.
REQ-033 slt with A=0x80000000, B=0x7FFFFFFF, op=00011 -> result=1; sgt with the same operands, op=01011 -> result=0 (overflow case).
REQ-034 MUL with A=0x0001_0003, B=0x0000_0005 and ALU_PIPE_MUL_EN defined -> result=0x0005_000F after 33 cycles, with in_ready=0 for cycles 1..32; without the macro -> result=0, err=1 after 1 cycle.
REQ-035 add 1+2 accepted, out_ready=0 for 3 cycles, then 1 -> result=3 stable and in_ready=0 throughout the stall; a back-to-back xor is accepted in the same cycle as the handoff.
REQ-036 rst pulsed for 1 cycle at MUL cycle 10 -> out_valid stays 0, state returns to IDLE, and in_ready=1 on the next cycle.
REQ-037 op=11010 -> result=0, zero_out=1, err=1.
